// File: rtl/flow_ctrl.sv
// flow_ctrl: central pipeline flow controller.
//
// Decides, each cycle, whether the PC register and the IF/ID and ID/EX
// pipeline registers advance (WORK), hold (STOP) or flush (REFRESH). It also
// tells the PC whether to take PC+4 or load a redirect target. It arbitrates
// debug halt, bus wait, pending redirects, interrupts, jumps, divider busy and
// load-use hazards. A redirect that arrives while the PC is frozen is parked in
// a one-entry pending slot and applied on the first cycle the PC can move.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   jump_req_i      EX branch/jump taken, target on jump_addr_i
//   int_req_i       interrupt request (level), vector on int_addr_i
//   int_ack_o       pulse: interrupt redirect taken/captured this cycle
//   load_use_i      load-use hazard in ID
//   div_busy_i      multi-cycle divider busy in EX
//   bus_wait_i      instruction/data bus not ready
//   jtag_halt_i     debug halt request (level)
//   halted_o        core is halted
//   flow_pc_o       PC register flow code
//   flow_if_id_o    IF/ID register flow code
//   flow_id_ex_o    ID/EX register flow code
//   next_pc_four_o  1 = PC+4, 0 = load next_pc_o
//   next_pc_o       redirect target
//   stall_cnt_o     saturating count of cycles with the PC stopped

`ifndef FLOW_WORK
`define FLOW_WORK 2'd0
`endif
`ifndef FLOW_STOP
`define FLOW_STOP 2'd1
`endif
`ifndef FLOW_REFRESH
`define FLOW_REFRESH 2'd2
`endif

module flow_ctrl #(
  parameter int CPU_WIDTH    = 32,
  parameter int FLOW_WIDTH   = 2,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump_req_i,
  input  logic [CPU_WIDTH-1:0]  jump_addr_i,
  input  logic                  int_req_i,
  input  logic [CPU_WIDTH-1:0]  int_addr_i,
  output logic                  int_ack_o,
  input  logic                  load_use_i,
  input  logic                  div_busy_i,
  input  logic                  bus_wait_i,
  input  logic                  jtag_halt_i,
  output logic                  halted_o,
  output logic [FLOW_WIDTH-1:0] flow_pc_o,
  output logic [FLOW_WIDTH-1:0] flow_if_id_o,
  output logic [FLOW_WIDTH-1:0] flow_id_ex_o,
  output logic                  next_pc_four_o,
  output logic [CPU_WIDTH-1:0]  next_pc_o,
  output logic [31:0]           stall_cnt_o
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [FLOW_WIDTH-1:0] F_WORK    = FLOW_WIDTH'(`FLOW_WORK);
  localparam logic [FLOW_WIDTH-1:0] F_STOP    = FLOW_WIDTH'(`FLOW_STOP);
  localparam logic [FLOW_WIDTH-1:0] F_REFRESH = FLOW_WIDTH'(`FLOW_REFRESH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic                   pend_vld, pend_vld_nxt;
  logic [CPU_WIDTH-1:0]   pend_addr, pend_addr_nxt;
  logic [DRAIN_W-1:0]     drain_cnt, drain_cnt_nxt;
  logic [31:0]            stall_cnt_nxt;

  // State register (plus the small amount of state that travels with it)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_RUN;
      pend_vld    <= 1'b0;
      pend_addr   <= '0;
      drain_cnt   <= '0;
      stall_cnt_o <= '0;
    end else begin
      state       <= state_nxt;
      pend_vld    <= pend_vld_nxt;
      pend_addr   <= pend_addr_nxt;
      drain_cnt   <= drain_cnt_nxt;
      stall_cnt_o <= stall_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt     = state;
    pend_vld_nxt  = pend_vld;
    pend_addr_nxt = pend_addr;
    drain_cnt_nxt = drain_cnt;
    unique case (state)
      S_RUN: begin
        if (jtag_halt_i) begin
          state_nxt     = S_DRAIN;
          drain_cnt_nxt = DRAIN_W'(DRAIN_CYCLES - 1);
        end else if (bus_wait_i) begin
          // PC frozen: park the redirect; an interrupt beats a jump and
          // either one overwrites an earlier parked target.
          if (int_req_i) begin
            pend_vld_nxt  = 1'b1;
            pend_addr_nxt = int_addr_i;
          end else if (jump_req_i) begin
            pend_vld_nxt  = 1'b1;
            pend_addr_nxt = jump_addr_i;
          end
        end else if (pend_vld) begin
          pend_vld_nxt = 1'b0;
        end
      end
      S_DRAIN: begin
        // Jumps resolved by the draining EX stage must not be lost.
        if (jump_req_i) begin
          pend_vld_nxt  = 1'b1;
          pend_addr_nxt = jump_addr_i;
        end
        if (!jtag_halt_i) begin
          state_nxt = S_RUN;
        end else if (drain_cnt == '0) begin
          state_nxt = S_HALT;
        end else if (!bus_wait_i) begin
          drain_cnt_nxt = drain_cnt - DRAIN_W'(1);
        end
      end
      S_HALT: begin
        if (!jtag_halt_i) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // Saturating stall counter
  always_comb begin
    stall_cnt_nxt = stall_cnt_o;
    if ((flow_pc_o == F_STOP) && (stall_cnt_o != 32'hFFFF_FFFF))
      stall_cnt_nxt = stall_cnt_o + 32'd1;
  end

  // Output logic
  always_comb begin
    flow_pc_o      = F_WORK;
    flow_if_id_o   = F_WORK;
    flow_id_ex_o   = F_WORK;
    next_pc_four_o = 1'b1;
    next_pc_o      = pend_addr;
    int_ack_o      = 1'b0;
    halted_o       = 1'b0;
    unique case (state)
      S_RUN: begin
        if (jtag_halt_i) begin
          // Freeze fetch, flush IF/ID, let the instruction in ID move to EX.
          flow_pc_o    = F_STOP;
          flow_if_id_o = F_REFRESH;
          flow_id_ex_o = F_WORK;
        end else if (bus_wait_i) begin
          flow_pc_o    = F_STOP;
          flow_if_id_o = F_STOP;
          flow_id_ex_o = F_STOP;
          int_ack_o    = int_req_i;
        end else if (pend_vld) begin
          next_pc_four_o = 1'b0;
          next_pc_o      = pend_addr;
          flow_if_id_o   = F_REFRESH;
          flow_id_ex_o   = F_REFRESH;
        end else if (int_req_i && !div_busy_i) begin
          next_pc_four_o = 1'b0;
          next_pc_o      = int_addr_i;
          int_ack_o      = 1'b1;
          flow_if_id_o   = F_REFRESH;
          flow_id_ex_o   = F_REFRESH;
        end else if (jump_req_i) begin
          next_pc_four_o = 1'b0;
          next_pc_o      = jump_addr_i;
          flow_if_id_o   = F_REFRESH;
          flow_id_ex_o   = F_REFRESH;
        end else if (div_busy_i) begin
          flow_pc_o    = F_STOP;
          flow_if_id_o = F_STOP;
          flow_id_ex_o = F_STOP;
        end else if (load_use_i) begin
          // Hold PC and IF/ID, inject a bubble into EX.
          flow_pc_o    = F_STOP;
          flow_if_id_o = F_STOP;
          flow_id_ex_o = F_REFRESH;
        end
      end
      S_DRAIN: begin
        flow_pc_o    = F_STOP;
        flow_if_id_o = F_REFRESH;
        flow_id_ex_o = F_REFRESH;
      end
      S_HALT: begin
        halted_o     = 1'b1;
        flow_pc_o    = F_STOP;
        flow_if_id_o = F_STOP;
        flow_id_ex_o = F_STOP;
      end
      default: begin
        flow_pc_o    = F_STOP;
        flow_if_id_o = F_STOP;
        flow_id_ex_o = F_STOP;
      end
    endcase
    if (!rst_n) begin
      flow_pc_o      = F_REFRESH;
      flow_if_id_o   = F_REFRESH;
      flow_id_ex_o   = F_REFRESH;
      next_pc_four_o = 1'b1;
      next_pc_o      = '0;
      int_ack_o      = 1'b0;
      halted_o       = 1'b0;
    end
  end

endmodule
